fir_seq_controller: RTL and testbench

- Parametrised sequencer for the sample-window averaging datapath. It drives register-file opcodes and addresses, plus handshake flags.
- On each data-ready it loads a new sample, shifts the N-tap window, then accumulates the window into register 0.
- Successor to the fixed 4-tap controller. Adds runtime-selectable tap count, indexed (counter-driven) shift/accumulate phases, a registered glitch-free modwait, and a functional cnt_up.
- Sits between the sample input handshake and the register-file/ALU datapath.

---
 rtl/fir_seq_controller_if.sv | 26 ++
 rtl/fir_seq_controller.sv | 152 +++++++++++++++
 tb/tb_fir_seq_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fir_seq_controller_if.sv
// Handshake and register-file command bundle between the sample sequencer and the datapath.
interface fir_seq_controller_if #(
  parameter int ADDR_W = 4,
  parameter int TAP_W  = 3
);
  logic              dr;
  logic              overflow;
  logic [TAP_W-1:0]  taps_sel;
  logic              cnt_up;
  logic              modwait;
  logic [1:0]        op;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] dest;
  logic              err;

  modport master (
    input  dr, overflow, taps_sel,
    output cnt_up, modwait, op, src1, src2, dest, err
  );

  modport slave (
    output dr, overflow, taps_sel,
    input  cnt_up, modwait, op, src1, src2, dest, err
  );
endinterface

// File: rtl/fir_seq_controller.sv
// Sample-window sequencer: LOAD a sample, shift the n-tap window down by one, then sum it into reg 0.
// Busy for 2*n cycles per accepted sample; dr is only looked at in IDLE/EIDLE/STORE.
module fir_seq_controller #(
  parameter int MAX_TAPS = 4,
  parameter int ADDR_W   = 4,
  parameter int TAP_W    = $clog2(MAX_TAPS + 1)
) (
  input logic             clk,
  input logic             n_reset,
  fir_seq_controller_if.master bus
);
  localparam int IDX_W = $clog2(MAX_TAPS + 2);
  localparam logic [ADDR_W-1:0] NONE = '1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EIDLE = 3'd1,
    S_STORE = 3'd2,
    S_SHIFT = 3'd3,
    S_ACC1  = 3'd4,
    S_ACCN  = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  idx, next_idx;
  logic [IDX_W-1:0]  tap_n, next_tap_n;
  logic [IDX_W-1:0]  n_clamped;
  logic              modwait_q;

  logic [1:0]        op_c;
  logic [ADDR_W-1:0] src1_c, src2_c, dest_c;
  logic              err_c, cnt_up_c;

  always_comb begin
    if (int'(bus.taps_sel) < 2)
      n_clamped = IDX_W'(2);
    else if (int'(bus.taps_sel) > MAX_TAPS)
      n_clamped = IDX_W'(MAX_TAPS);
    else
      n_clamped = IDX_W'(bus.taps_sel);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      tap_n     <= IDX_W'(MAX_TAPS);
      modwait_q <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      tap_n     <= next_tap_n;
      modwait_q <= (next_state != S_IDLE) && (next_state != S_EIDLE);
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_tap_n = tap_n;
    case (state)
      S_IDLE, S_EIDLE: begin
        if (bus.dr) begin
          next_state = S_STORE;
          next_tap_n = n_clamped;
        end
      end
      S_STORE: begin
        if (bus.dr) begin
          next_state = S_SHIFT;
          next_idx   = IDX_W'(1);
        end else begin
          next_state = S_EIDLE;
        end
      end
      S_SHIFT: begin
        if (idx == tap_n)
          next_state = S_ACC1;
        else
          next_idx = idx + IDX_W'(1);
      end
      S_ACC1: begin
        if (bus.overflow) begin
          next_state = S_EIDLE;
        end else if (tap_n == IDX_W'(2)) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_ACCN;
          next_idx   = IDX_W'(3);
        end
      end
      S_ACCN: begin
        if (bus.overflow)
          next_state = S_EIDLE;
        else if (idx == tap_n)
          next_state = S_IDLE;
        else
          next_idx = idx + IDX_W'(1);
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Unknown encodings fall through the defaults and look exactly like IDLE.
  always_comb begin
    op_c     = OP_NOP;
    src1_c   = NONE;
    src2_c   = NONE;
    dest_c   = NONE;
    err_c    = 1'b0;
    cnt_up_c = 1'b0;
    case (state)
      S_EIDLE: err_c = 1'b1;
      S_STORE: begin
        op_c     = OP_LOAD;
        dest_c   = ADDR_W'(tap_n + IDX_W'(1));
        cnt_up_c = bus.dr;
      end
      S_SHIFT: begin
        op_c   = OP_COPY;
        src1_c = ADDR_W'(idx + IDX_W'(1));
        dest_c = ADDR_W'(idx);
      end
      S_ACC1: begin
        op_c   = OP_ADD;
        src1_c = ADDR_W'(1);
        src2_c = ADDR_W'(2);
        dest_c = '0;
      end
      S_ACCN: begin
        op_c   = OP_ADD;
        src1_c = ADDR_W'(idx);
        src2_c = '0;
        dest_c = '0;
      end
      default: ;
    endcase
  end

  assign bus.op      = op_c;
  assign bus.src1    = src1_c;
  assign bus.src2    = src2_c;
  assign bus.dest    = dest_c;
  assign bus.err     = err_c;
  assign bus.cnt_up  = cnt_up_c;
  assign bus.modwait = modwait_q;
endmodule

// File: tb/tb_fir_seq_controller.sv
// Directed bench for fir_seq_controller: per-cycle expected command words queued and compared.
module tb_fir_seq_controller;
  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] COPY = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] ADD  = 2'b11;
  localparam logic [3:0] NA   = 4'hF;

  logic clk;
  logic n_reset;
  int   checks;
  int   failures;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  fir_seq_controller_if #(.ADDR_W(4), .TAP_W(3)) bus ();

  fir_seq_controller #(.MAX_TAPS(4), .ADDR_W(4), .TAP_W(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [1:0] op, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [3:0] d, input logic cu, input logic er, input logic mw,
                          input string tag);
    exp_q.push_back({op, s1, s2, d, cu, er, mw});
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [16:0] obs;
    logic [16:0] ev;
    string       tg;
    obs = {bus.op, bus.src1, bus.src2, bus.dest, bus.cnt_up, bus.err, bus.modwait};
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty obs=%h exp=entry", obs);
    end else begin
      ev = exp_q.pop_front();
      tg = tag_q.pop_front();
      checks++;
      assert (obs === ev) else begin
        failures++;
        $error("FAIL %s obs{op,s1,s2,d,cu,err,mw}=%h exp=%h", tg, obs, ev);
      end
    end
  endtask

  // Called at posedge+1: drive inputs, queue what this cycle must show, check, advance.
  task automatic cyc(input logic d, input logic ov, input logic [2:0] ts,
                     input logic [1:0] op, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] dst, input logic cu, input logic er, input logic mw,
                     input string tag);
    bus.dr       = d;
    bus.overflow = ov;
    bus.taps_sel = ts;
    push_exp(op, s1, s2, dst, cu, er, mw, tag);
    #1;
    pop_check();
    @(posedge clk);
    #1;
  endtask

  // Remainder of an n=4 run after STORE: four COPYs, three ADDs, then IDLE.
  task automatic tail4(input logic d, input logic [2:0] ts, input string tag);
    cyc(d, 1'b0, ts, COPY, 4'd2, NA, 4'd1, 1'b0, 1'b0, 1'b1, {tag, "_sh1"});
    cyc(d, 1'b0, ts, COPY, 4'd3, NA, 4'd2, 1'b0, 1'b0, 1'b1, {tag, "_sh2"});
    cyc(d, 1'b0, ts, COPY, 4'd4, NA, 4'd3, 1'b0, 1'b0, 1'b1, {tag, "_sh3"});
    cyc(d, 1'b0, ts, COPY, 4'd5, NA, 4'd4, 1'b0, 1'b0, 1'b1, {tag, "_sh4"});
    cyc(d, 1'b0, ts, ADD,  4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, {tag, "_acc1"});
    cyc(d, 1'b0, ts, ADD,  4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, {tag, "_acc3"});
    cyc(d, 1'b0, ts, ADD,  4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, {tag, "_acc4"});
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    n_reset      = 1'b0;
    bus.dr       = 1'b0;
    bus.overflow = 1'b0;
    bus.taps_sel = 3'd4;
    #2;
    push_exp(NOP, NA, NA, NA, 1'b0, 1'b0, 1'b0, "reset_state");
    pop_check();
    #10 n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Full n=4 run
    cyc(1'b1, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "n4_idle");
    cyc(1'b1, 1'b0, 3'd4, LOAD, NA, NA, 4'd5, 1'b1, 1'b0, 1'b1, "n4_store");
    tail4(1'b0, 3'd4, "n4");
    cyc(1'b0, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "n4_done");

    // Aborted sample: STORE without dr, sticky err, recovery
    cyc(1'b1, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "ab_idle");
    cyc(1'b0, 1'b0, 3'd4, LOAD, NA, NA, 4'd5, 1'b0, 1'b0, 1'b1, "ab_store");
    cyc(1'b0, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b1, 1'b0, "ab_eidle1");
    cyc(1'b1, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b1, 1'b0, "ab_eidle2");
    cyc(1'b1, 1'b0, 3'd4, LOAD, NA, NA, 4'd5, 1'b1, 1'b0, 1'b1, "ab_restore");

    // Overflow during ADD(3,0->0)
    cyc(1'b0, 1'b0, 3'd4, COPY, 4'd2, NA, 4'd1, 1'b0, 1'b0, 1'b1, "ov_sh1");
    cyc(1'b0, 1'b0, 3'd4, COPY, 4'd3, NA, 4'd2, 1'b0, 1'b0, 1'b1, "ov_sh2");
    cyc(1'b0, 1'b0, 3'd4, COPY, 4'd4, NA, 4'd3, 1'b0, 1'b0, 1'b1, "ov_sh3");
    cyc(1'b0, 1'b0, 3'd4, COPY, 4'd5, NA, 4'd4, 1'b0, 1'b0, 1'b1, "ov_sh4");
    cyc(1'b0, 1'b0, 3'd4, ADD,  4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, "ov_acc1");
    cyc(1'b0, 1'b1, 3'd4, ADD,  4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "ov_acc3");
    cyc(1'b0, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b1, 1'b0, "ov_eidle");
    cyc(1'b0, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b1, 1'b0, "ov_no_acc4");

    // n=2 accepted from EIDLE
    cyc(1'b1, 1'b0, 3'd2, NOP,  NA, NA, NA,   1'b0, 1'b1, 1'b0, "n2_eidle");
    cyc(1'b1, 1'b0, 3'd2, LOAD, NA, NA, 4'd3, 1'b1, 1'b0, 1'b1, "n2_store");
    cyc(1'b0, 1'b0, 3'd2, COPY, 4'd2, NA, 4'd1, 1'b0, 1'b0, 1'b1, "n2_sh1");
    cyc(1'b0, 1'b0, 3'd2, COPY, 4'd3, NA, 4'd2, 1'b0, 1'b0, 1'b1, "n2_sh2");
    cyc(1'b0, 1'b0, 3'd2, ADD,  4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, "n2_acc1");

    // Back-to-back with taps_sel=0 clamped to 2; taps_sel=7 mid-run ignored
    cyc(1'b1, 1'b0, 3'd0, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "t0_idle_b2b");
    cyc(1'b1, 1'b0, 3'd0, LOAD, NA, NA, 4'd3, 1'b1, 1'b0, 1'b1, "t0_store");
    cyc(1'b0, 1'b0, 3'd7, COPY, 4'd2, NA, 4'd1, 1'b0, 1'b0, 1'b1, "t0_sh1");
    cyc(1'b0, 1'b0, 3'd7, COPY, 4'd3, NA, 4'd2, 1'b0, 1'b0, 1'b1, "t0_sh2");
    cyc(1'b0, 1'b0, 3'd7, ADD,  4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, "t0_acc1");

    // taps_sel=7 clamped to 4, then async reset in SHIFT idx=2
    cyc(1'b1, 1'b0, 3'd7, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "t7_idle");
    cyc(1'b1, 1'b0, 3'd7, LOAD, NA, NA, 4'd5, 1'b1, 1'b0, 1'b1, "t7_store");
    cyc(1'b0, 1'b0, 3'd0, COPY, 4'd2, NA, 4'd1, 1'b0, 1'b0, 1'b1, "t7_sh1");
    push_exp(COPY, 4'd3, NA, 4'd2, 1'b0, 1'b0, 1'b1, "t7_sh2");
    pop_check();
    n_reset = 1'b0;
    #1;
    push_exp(NOP, NA, NA, NA, 1'b0, 1'b0, 1'b0, "async_reset");
    pop_check();
    @(posedge clk);
    #4 n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Full n=4 run after reset, dr held high throughout busy
    cyc(1'b1, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "rr_idle");
    cyc(1'b1, 1'b0, 3'd4, LOAD, NA, NA, 4'd5, 1'b1, 1'b0, 1'b1, "rr_store");
    tail4(1'b1, 3'd4, "rr");
    cyc(1'b1, 1'b0, 3'd4, NOP,  NA, NA, NA,   1'b0, 1'b0, 1'b0, "rr_done");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
